// File: rtl/i2s_read_if.sv
// rtl/i2s_read_if.sv - sample-pair handshake bundle between the I2S receiver and its consumer
interface i2s_read_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] left_data;
  logic [WIDTH-1:0] right_data;
  logic             valid;
  logic             ready;
  logic             overrun;

  modport master (
    output left_data,
    output right_data,
    output valid,
    output overrun,
    input  ready
  );

  modport slave (
    input  left_data,
    input  right_data,
    input  valid,
    input  overrun,
    output ready
  );
endinterface

// File: rtl/i2s_read.sv
// rtl/i2s_read.sv - I2S ADC receiver assembling left/right pairs onto a valid/ready bundle
// Optional I2S_READ_OVERRUN_EN: drop new pairs while the consumer stalls and raise sticky overrun.
module i2s_read #(
  parameter int WIDTH = 16
) (
  input  logic       clk_n,
  input  logic       rst,
  input  logic       adclrc,
  input  logic       adcdat,
  i2s_read_if.master rx
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEFT,
    LEFT_WAIT,
    RIGHT,
    RIGHT_WAIT
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] held;
  logic             held_ok;
  logic             lrc_d;

  logic             edge_ev;
  logic             rise_ev;
  logic             fall_ev;
  logic             last_bit;
  logic             deliver;
  logic [WIDTH-1:0] shift_nxt;

  always_comb begin
    edge_ev   = adclrc != lrc_d;
    rise_ev   = edge_ev & adclrc;
    fall_ev   = edge_ev & ~adclrc;
    shift_nxt = (shift << 1) | WIDTH'(adcdat);
    last_bit  = cnt == LAST;
    deliver   = (state == RIGHT) && last_bit && held_ok;
  end

`ifndef I2S_READ_OVERRUN_EN
  assign rx.overrun = 1'b0;
`endif

  always_ff @(posedge clk_n or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      shift         <= '0;
      held          <= '0;
      held_ok       <= 1'b0;
      lrc_d         <= 1'b0;
      rx.left_data  <= '0;
      rx.right_data <= '0;
      rx.valid      <= 1'b0;
`ifdef I2S_READ_OVERRUN_EN
      rx.overrun    <= 1'b0;
`endif
    end else begin
      lrc_d <= adclrc;

      case (state)
        IDLE: begin
          if (fall_ev) begin
            state <= LEFT;
            cnt   <= '0;
          end
        end
        LEFT: begin
          shift <= shift_nxt;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            held    <= shift_nxt;
            held_ok <= 1'b1;
            cnt     <= '0;
            // A frame edge landing on the LSB edge starts the right word straight away.
            state   <= rise_ev ? RIGHT : LEFT_WAIT;
          end else if (edge_ev) begin
            held_ok <= 1'b0;
            cnt     <= '0;
            state   <= adclrc ? RIGHT : LEFT;
          end
        end
        RIGHT: begin
          shift <= shift_nxt;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            held_ok <= 1'b0;
            cnt     <= '0;
            state   <= fall_ev ? LEFT : RIGHT_WAIT;
          end else if (edge_ev) begin
            held_ok <= 1'b0;
            cnt     <= '0;
            state   <= adclrc ? RIGHT : LEFT;
          end
        end
        LEFT_WAIT: begin
          if (rise_ev) begin
            state <= RIGHT;
            cnt   <= '0;
          end
        end
        RIGHT_WAIT: begin
          if (fall_ev) begin
            state <= LEFT;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      if (deliver) begin
        if (!rx.valid || rx.ready) begin
          rx.left_data  <= held;
          rx.right_data <= shift_nxt;
          rx.valid      <= 1'b1;
        end else begin
`ifdef I2S_READ_OVERRUN_EN
          rx.overrun    <= 1'b1;
`else
          rx.left_data  <= held;
          rx.right_data <= shift_nxt;
`endif
        end
      end else if (rx.valid && rx.ready) begin
        rx.valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2s_read.sv
// tb/tb_i2s_read.sv - self-checking bench for i2s_read (table frames, scoreboard, handshake corners)
module tb_i2s_read;
  localparam int W = 16;

  logic clk_n;
  logic rst;
  logic adclrc;
  logic adcdat;

  i2s_read_if #(.WIDTH(W)) rx ();

  i2s_read #(.WIDTH(W)) dut (
    .clk_n  (clk_n),
    .rst    (rst),
    .adclrc (adclrc),
    .adcdat (adcdat),
    .rx     (rx)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          lbits;
    int          rbits;
    int          pad;
    bit          want_pair;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_edge_cyc = 0;
  int          valid_cyc = 0;
  bit          mon_en = 0;
  logic        prev_valid = 0;
  logic [31:0] exp_pair;

  initial clk_n = 1'b0;
  always #5 clk_n = ~clk_n;

  always @(posedge clk_n) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // A new pair is one that appears while nothing was pending or the previous one was taken.
  always @(posedge clk_n) begin
    #1;
    if (mon_en && rx.valid && (!prev_valid || rx.ready)) begin
      valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_pair", {rx.left_data, rx.right_data}, 32'hxxxx_xxxx);
      end else begin
        exp_pair = exp_q.pop_front();
        chk("pair", {rx.left_data, rx.right_data}, exp_pair);
      end
    end
    prev_valid = rx.valid;
  end

  task automatic bitc(input logic lrc, input logic dat);
    @(negedge clk_n);
    adclrc = lrc;
    adcdat = dat;
  endtask

  task automatic send_word(input logic lrc, input logic [15:0] w, input int nbits, input int pad);
    bitc(lrc, 1'($urandom));
    last_edge_cyc = cyc + 1;
    for (int i = 0; i < nbits; i++) bitc(lrc, w[15-i]);
    for (int i = 0; i < pad; i++) bitc(lrc, 1'($urandom));
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input int lbits, input int rbits, input int pad);
    send_word(1'b0, l, lbits, (lbits == 16) ? pad : 0);
    send_word(1'b1, r, rbits, (rbits == 16) ? pad : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int e;
    vecs[0] = '{16'h5A5A, 16'h1234,  9, 16,  0, 1'b0};
    vecs[1] = '{16'h5555, 16'hAAAA, 16, 16,  0, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0000, 16, 16, 15, 1'b1};
    vecs[3] = '{16'hC0DE, 16'h7777, 16,  5,  0, 1'b0};
    vecs[4] = '{16'h1357, 16'h9BDF, 16, 16, 15, 1'b1};
    vecs[5] = '{16'h8001, 16'h7FFE, 16, 16,  0, 1'b1};

    rst      = 1'b0;
    adclrc   = 1'b1;
    adcdat   = 1'b0;
    rx.ready = 1'b0;
    repeat (3) @(negedge clk_n);
    rst = 1'b1;

    // Park a pair in the output stage so the reset has something to clear.
    send_frame(16'hDEAD, 16'hBEEF, 16, 16, 0);
    bitc(1'b1, 1'b0);
    chk("preload_valid", 32'(rx.valid), 32'd1);
    chk("preload_pair", {rx.left_data, rx.right_data}, 32'hDEAD_BEEF);
    send_word(1'b0, 16'h3C3C, 7, 0);
    #2 rst = 1'b0;
    #1;
    chk("rst_left", 32'(rx.left_data), 32'd0);
    chk("rst_right", 32'(rx.right_data), 32'd0);
    chk("rst_valid", 32'(rx.valid), 32'd0);
    chk("rst_overrun", 32'(rx.overrun), 32'd0);
    adclrc = 1'b1;
    repeat (2) @(negedge clk_n);
    rst = 1'b1;
    repeat (4) bitc(1'b1, 1'($urandom));

    rx.ready = 1'b1;
    mon_en   = 1'b1;
    exp_q.push_back({16'hA5C3, 16'h1234});
    send_word(1'b0, 16'hA5C3, 16, 0);
    e = last_edge_cyc;
    send_word(1'b1, 16'h1234, 16, 0);
    @(posedge clk_n);
    #2;
    chk("latency", 32'(valid_cyc - e), 32'd33);
    @(posedge clk_n);
    #2;
    chk("valid_pulse", 32'(rx.valid), 32'd0);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].want_pair) exp_q.push_back({vecs[i].l, vecs[i].r});
      send_frame(vecs[i].l, vecs[i].r, vecs[i].lbits, vecs[i].rbits, vecs[i].pad);
    end
    repeat (4) bitc(1'b1, 1'b0);
    mon_en = 1'b0;

    // Consumer takes the old pair on the very edge the next pair completes.
    rx.ready = 1'b0;
    send_frame(16'h1111, 16'h2222, 16, 16, 0);
    bitc(1'b1, 1'b0);
    chk("b2b_first_valid", 32'(rx.valid), 32'd1);
    chk("b2b_first_pair", {rx.left_data, rx.right_data}, 32'h1111_2222);
    send_word(1'b0, 16'h0001, 16, 0);
    send_word(1'b1, 16'h8000, 15, 0);
    @(negedge clk_n);
    adclrc   = 1'b1;
    adcdat   = 1'b0;
    rx.ready = 1'b1;
    @(posedge clk_n);
    #1;
    chk("b2b_valid", 32'(rx.valid), 32'd1);
    chk("b2b_pair", {rx.left_data, rx.right_data}, 32'h0001_8000);
    chk("b2b_overrun", 32'(rx.overrun), 32'd0);
    @(posedge clk_n);
    #1;
    chk("b2b_consumed", 32'(rx.valid), 32'd0);

    rx.ready = 1'b0;
    send_frame(16'hA5C3, 16'h1234, 16, 16, 0);
    send_frame(16'h0F0F, 16'hF0F0, 16, 16, 0);
    bitc(1'b1, 1'b0);
    chk("stall_valid", 32'(rx.valid), 32'd1);
`ifdef I2S_READ_OVERRUN_EN
    chk("stall_pair", {rx.left_data, rx.right_data}, 32'hA5C3_1234);
    chk("stall_overrun", 32'(rx.overrun), 32'd1);
`else
    chk("stall_pair", {rx.left_data, rx.right_data}, 32'h0F0F_F0F0);
    chk("stall_overrun", 32'(rx.overrun), 32'd0);
`endif
    rx.ready = 1'b1;
    @(posedge clk_n);
    #1;
    chk("stall_consumed", 32'(rx.valid), 32'd0);
`ifdef I2S_READ_OVERRUN_EN
    chk("overrun_sticky", 32'(rx.overrun), 32'd1);
`else
    chk("overrun_sticky", 32'(rx.overrun), 32'd0);
`endif
    rx.ready = 1'b0;

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
